// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: rescales row-DCT coefficients, writes them row-major and streams them out column-major.
// Define DCT_TPB_SAT_EN to saturate the rescaled value to OUT_W bits; without it the low OUT_W bits are kept.
module dct_transpose_buf #(
  parameter int OUT_W = 10,
  parameter int SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [14:0]      sum_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             overflow
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_t;
  typedef enum logic {R_IDLE, R_STREAM} rd_st_t;

  localparam logic [15:0] RND = 16'((32'd1 << SHIFT) >> 1);
  localparam int MAXI = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [15:0] MAXV = 16'(MAXI);
  localparam logic signed [15:0] MINV = 16'(-MAXI - 1);

  logic [OUT_W-1:0] mem [2][64];
  bank_st_t         st [2];
  logic             wr_bank, rd_bank;
  logic [5:0]       wr_idx, rd_idx;
  rd_st_t           rd_st;

  logic [15:0]        t;
  logic signed [15:0] r;
  logic [OUT_W-1:0]   scaled;
  logic               unused_hi;

  // Round-half-up: add half an LSB of the result before the arithmetic shift.
  always_comb begin
    t = {sum_in[14], sum_in} + RND;
    r = $signed(t) >>> SHIFT;
`ifdef DCT_TPB_SAT_EN
    if (r > MAXV)      scaled = MAXV[OUT_W-1:0];
    else if (r < MINV) scaled = MINV[OUT_W-1:0];
    else               scaled = r[OUT_W-1:0];
`else
    scaled = r[OUT_W-1:0];
`endif
  end
  assign unused_hi = ^r[15:OUT_W-1];

  logic wr_fire, wr_done, oth_full, sel;
  logic [5:0] nxt_idx, nxt_addr;

  assign in_ready = !(st[wr_bank] == B_FULL || st[wr_bank] == B_DRAINING);
  assign wr_fire  = in_valid && in_ready;
  assign wr_done  = wr_fire && (wr_idx == 6'd63);
  // A bank completing on this very edge counts as full so the reader chains without a bubble.
  assign oth_full = (st[~rd_bank] == B_FULL) || (wr_done && (wr_bank == ~rd_bank));
  assign sel      = (st[~wr_bank] == B_FULL) ? ~wr_bank : wr_bank;
  assign nxt_idx  = rd_idx + 6'd1;
  assign nxt_addr = {nxt_idx[2:0], nxt_idx[5:3]};

  always_ff @(posedge clk) begin
    if (rst_n && wr_fire) mem[wr_bank][wr_idx] <= scaled;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st[0]     <= B_EMPTY;
      st[1]     <= B_EMPTY;
      wr_bank   <= 1'b0;
      wr_idx    <= 6'd0;
      rd_bank   <= 1'b0;
      rd_idx    <= 6'd0;
      rd_st     <= R_IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_idx <= wr_idx + 6'd1;
        if (wr_done) begin
          st[wr_bank] <= B_FULL;
          wr_bank     <= ~wr_bank;
        end else if (st[wr_bank] == B_EMPTY) begin
          st[wr_bank] <= B_FILLING;
        end
      end
      if (in_valid && !in_ready) overflow <= 1'b1;

      // Reader updates follow the writer so a same-edge FULL->DRAINING wins.
      case (rd_st)
        R_IDLE: begin
          if (st[0] == B_FULL || st[1] == B_FULL) begin
            rd_bank   <= sel;
            st[sel]   <= B_DRAINING;
            rd_idx    <= 6'd0;
            out_data  <= mem[sel][6'd0];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            rd_st     <= R_STREAM;
          end
        end
        R_STREAM: begin
          if (!out_valid || out_ready) begin
            if (out_last) begin
              st[rd_bank] <= B_EMPTY;
              if (oth_full) begin
                rd_bank      <= ~rd_bank;
                st[~rd_bank] <= B_DRAINING;
                rd_idx       <= 6'd0;
                out_data     <= mem[~rd_bank][6'd0];
                out_last     <= 1'b0;
              end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                rd_st     <= R_IDLE;
              end
            end else begin
              rd_idx   <= nxt_idx;
              out_data <= mem[rd_bank][nxt_addr];
              out_last <= (nxt_idx == 6'd63);
            end
          end
        end
        default: rd_st <= R_IDLE;
      endcase
    end
  end

endmodule
